// File: rtl/multiplier_unsigned_seq.sv
// Iterative shift-add unsigned multiplier.
// Retires one multiplier bit per clock and produces the full 2*WIDTH-bit product
// after exactly WIDTH busy cycles. Valid/ready handshake on both sides, one op in flight.
module multiplier_unsigned_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH:0]       sum;

  // Next-state and datapath: the accumulator holds {partial product, remaining multiplier bits};
  // each busy step adds A when the current multiplier bit is set, then shifts right with the carry entering the MSB.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_multiplicand;
          acc_d   = {{WIDTH{1'b0}}, i_multiplier};
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = {sum, acc_q[WIDTH-1:1]};
          state_d   = DONE;
        end
      end
      DONE: begin
        if (i_out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears the result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_busy    = (state_q == BUSY);
  assign o_valid   = (state_q == DONE);
  assign o_product = product_q;

endmodule

// File: doc/multiplier_unsigned_seq.md
Name: multiplier_unsigned_seq

Overview:
- Iterative shift-add unsigned multiplier: WIDTH x WIDTH operands -> 2*WIDTH product, one multiplier bit retired per clock.
- Counterpart to the combinational unsigned divider in the arithmetic unit; shares its operand conventions (i_/o_ ports, unsigned).
- Consumed by the same datapath so quotient * divisor + remainder == dividend can be checked in-system.
- Valid/ready handshake on input and output; one operation in flight.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH. Legal range 2..64.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  operands present on i_multiplicand/i_multiplier
- o_ready  output  1  block can accept an operation (state IDLE)
- i_multiplicand  input  WIDTH  unsigned operand A
- i_multiplier  input  WIDTH  unsigned operand B
- o_valid  output  1  o_product holds a completed result (state DONE)
- i_out_ready  input  1  downstream accepts the result
- o_product  output  2*WIDTH  unsigned A*B
- o_busy  output  1  iteration in progress (state BUSY)

Behaviour:
- Reset (i_rst=1, immediate, no clock needed): state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_product=0, iteration counter=0, internal accumulator=0.
- FSM states: IDLE, BUSY, DONE. o_ready = (state==IDLE); o_busy = (state==BUSY); o_valid = (state==DONE).
- IDLE: on an edge with i_valid=1, latch A and B; clear the accumulator upper half; load B into the accumulator lower half; set counter=0; go to BUSY. If i_valid=0, stay in IDLE.
- Operands are sampled only at acceptance. Input changes during BUSY/DONE are ignored. i_valid while o_ready=0 is ignored and not queued.
- BUSY, each edge:
  - sum = acc_hi + (acc_lo[0] ? A : 0), computed at WIDTH+1 bits.
  - New accumulator = {sum, acc_lo} >> 1, logical, so the carry enters the MSB.
  - Counter increments.
  - On the edge where counter == WIDTH-1, that iteration completes, o_product is loaded with the final accumulator, and the state goes to DONE.
- Latency is fixed:
  - Exactly WIDTH BUSY edges after the acceptance edge; o_valid rises right after the WIDTH-th of them.
  - No early termination for zero or one operands.
- o_product changes only on the BUSY->DONE edge and on reset. It holds through DONE, IDLE and the next BUSY, until the next completion.
- DONE:
  - Holds while i_out_ready=0 (back-pressure); o_product stays stable.
  - On an edge with i_out_ready=1, goes to IDLE; o_valid drops and o_ready rises after that edge.
  - There is no DONE->BUSY bypass; a new operation needs one IDLE cycle.
- Throughput: at most one result per WIDTH+2 cycles.
- Arithmetic: the full 2*WIDTH product is kept with no truncation. The maximum is (2^WIDTH-1)^2, which fits exactly.
- Reset mid-operation (BUSY or DONE): abort, apply the reset values above. The partial result is discarded and o_product=0.
- i_out_ready is don't-care outside DONE.

Test Plan:
- Reset: assert i_rst asynchronously mid-cycle. Required immediately: o_ready=1, o_valid=0, o_busy=0, o_product=0.
- Basic, WIDTH=32:
  - Stimulus: A=12345, B=6789, i_valid pulse one cycle, i_out_ready=1.
  - Required: o_valid high exactly 32 cycles after the acceptance edge, o_product=83810205 (0x0000_0000_04FE_D79D), return to IDLE one cycle later.
- Max/carry: A=B=0xFFFFFFFF -> o_product=0xFFFFFFFE_00000001.
- Zeros and ones, each with the same 32-cycle latency:
  - A=0, B=0xDEADBEEF -> 0
  - A=0xDEADBEEF, B=1 -> 0x00000000_DEADBEEF
  - A=1, B=0x80000000 -> 0x00000000_80000000
- Back-pressure and ignore:
  - Stimulus: i_out_ready=0 for 10 cycles after o_valid; toggle i_valid and the operands throughout BUSY and DONE.
  - Required: o_valid and o_product stay stable, no new operation starts, release returns to IDLE.
  - Then a new op A=3, B=5 -> 15, with the previous o_product held until that completion.
- Reset mid-op: assert i_rst at BUSY cycle 16 of A=B=0xFFFFFFFF.
  - Required: immediate IDLE with o_product=0.
  - Then A=7, B=6 -> 42 with normal latency.
- Randomized scoreboard cross-check: A*B against a reference model. Also drive the divider and check q*d+r against its dividend.
